// File: rtl/mario_snd_pkg.sv
// rtl/mario_snd_pkg.sv - shared types and constants for the sound sample ROM download path
//
// Contents: wav loader FSM state enum, default sample window size, sample ROM
// word/byte address widths and the byte offsets of the three sample regions.
package mario_snd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wavld_state_t;

    // 8192 x 16-bit words = 16 KiB of sample bytes
    localparam logic [16:0] WIN_SIZE_DEF = 17'h04000;

    localparam int SROM_AW = 13;    // sample ROM word address width
    localparam int DL_AW   = 17;    // download bus byte address width

    localparam logic [DL_AW-1:0] REGION_OFS_0 = 17'h00000;
    localparam logic [DL_AW-1:0] REGION_OFS_1 = 17'h01000;
    localparam logic [DL_AW-1:0] REGION_OFS_2 = 17'h02000;

endpackage

// File: rtl/wavld_pacer.sv
// rtl/wavld_pacer.sv - one-entry byte buffer and write-gap pacer for the sample ROM bus
//
// Ports:
//   I_CLK_48M, I_RESETn   clock, synchronous active-low reset
//   clear                 drop any buffered byte (new session)
//   push                  store push_addr/push_data into the buffer (only when hold is low)
//   hold                  registered: buffer full or gap counter running
//   dlwr                  one-clock write pulse, dladdr/dldata valid with it
//   dladdr, dldata        buffered byte; held until the next push
//   idle                  buffer empty and gap counter at zero
module wavld_pacer
    import mario_snd_pkg::*;
#(
    parameter int WR_GAP = 4
) (
    input  logic             I_CLK_48M,
    input  logic             I_RESETn,
    input  logic             clear,
    input  logic             push,
    input  logic [DL_AW-1:0] push_addr,
    input  logic [7:0]       push_data,
    output logic             hold,
    output logic             dlwr,
    output logic [DL_AW-1:0] dladdr,
    output logic [7:0]       dldata,
    output logic             idle
);

    localparam logic [3:0] GAP_RELOAD = 4'(WR_GAP - 1);

    logic             full;
    logic             full_nxt;
    logic [3:0]       gap;
    logic [3:0]       gap_nxt;
    logic [DL_AW-1:0] buf_addr;
    logic [7:0]       buf_data;

    // The buffered byte goes out as soon as the gap has elapsed; the pulse is
    // decoded from registers so it lands one clock after the host strobe.
    assign dlwr   = full && (gap == 4'd0);
    assign dladdr = buf_addr;
    assign dldata = buf_data;
    assign idle   = !full && (gap == 4'd0);

    always_comb begin
        full_nxt = full;
        gap_nxt  = gap;
        if (dlwr) begin
            full_nxt = 1'b0;
            gap_nxt  = GAP_RELOAD;
        end else if (gap != 4'd0) begin
            gap_nxt = gap - 4'd1;
        end
        if (clear) begin
            full_nxt = 1'b0;
        end
        if (push) begin
            full_nxt = 1'b1;
        end
    end

    always_ff @(posedge I_CLK_48M) begin
        if (!I_RESETn) begin
            full     <= 1'b0;
            gap      <= 4'd0;
            hold     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            full <= full_nxt;
            gap  <= gap_nxt;
            // Hold is computed from next-state values so the host sees it
            // the very clock after the byte is taken.
            hold <= full_nxt || (gap_nxt != 4'd0);
            if (push) begin
                buf_addr <= push_addr;
                buf_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/mario_wav_loader.sv
// rtl/mario_wav_loader.sv - host download writer for the sound sample ROM
//
// Filters host bytes to the sample window, rebases them to a sample ROM byte
// address and emits paced single-byte writes. Tracks session completion and
// keeps playback muted until a full, clean window has been written.
//
// Ports:
//   I_CLK_48M, I_RESETn                      clock, synchronous active-low reset
//   I_DL_ACTIVE                              host download session level
//   I_IOCTL_ADDR/DATA/WR                     host byte stream
//   O_IOCTL_WAIT                             host back-pressure
//   O_DLADDR/O_DLDATA/O_DLWR                 sample ROM download bus
//   O_MUTE, O_DONE, O_OVERRUN, O_BYTES       session status
//   O_CHKSUM                                 additive byte checksum
//
// Build option: WAVLD_CHKSUM_EN enables the O_CHKSUM adder; otherwise O_CHKSUM is 0.
module mario_wav_loader
    import mario_snd_pkg::*;
#(
    parameter logic [24:0]      BASE_ADDR = 25'h0010000,
    parameter logic [DL_AW-1:0] WIN_SIZE  = WIN_SIZE_DEF,
    parameter int               WR_GAP    = 4
) (
    input  logic             I_CLK_48M,
    input  logic             I_RESETn,
    input  logic             I_DL_ACTIVE,
    input  logic [24:0]      I_IOCTL_ADDR,
    input  logic [7:0]       I_IOCTL_DATA,
    input  logic             I_IOCTL_WR,
    output logic             O_IOCTL_WAIT,
    output logic [DL_AW-1:0] O_DLADDR,
    output logic [7:0]       O_DLDATA,
    output logic             O_DLWR,
    output logic             O_MUTE,
    output logic             O_DONE,
    output logic             O_OVERRUN,
    output logic [DL_AW-1:0] O_BYTES,
    output logic [15:0]      O_CHKSUM
);

    localparam logic [24:0] WIN_END = BASE_ADDR + 25'(WIN_SIZE);

    wavld_state_t     state;
    wavld_state_t     state_nxt;
    logic             dl_q;
    logic             dl_rise;
    logic             dl_fall;
    logic             enter_load;
    logic             in_window;
    logic             strobe_hit;
    logic             push;
    logic             pacer_idle;
    logic [DL_AW-1:0] rel_addr;
    logic [DL_AW-1:0] bytes_q;
    logic             overrun_q;

    assign dl_rise    = I_DL_ACTIVE && !dl_q;
    assign dl_fall    = !I_DL_ACTIVE && dl_q;
    assign in_window  = (I_IOCTL_ADDR >= BASE_ADDR) && (I_IOCTL_ADDR < WIN_END);
    assign strobe_hit = I_IOCTL_WR && (state == ST_LOAD) && in_window;
    assign push       = strobe_hit && !O_IOCTL_WAIT;
    assign rel_addr   = I_IOCTL_ADDR[DL_AW-1:0] - BASE_ADDR[DL_AW-1:0];
    assign enter_load = (state_nxt == ST_LOAD) && (state != ST_LOAD);

    wavld_pacer #(
        .WR_GAP (WR_GAP)
    ) u_pacer (
        .I_CLK_48M (I_CLK_48M),
        .I_RESETn  (I_RESETn),
        .clear     (enter_load),
        .push      (push),
        .push_addr (rel_addr),
        .push_data (I_IOCTL_DATA),
        .hold      (O_IOCTL_WAIT),
        .dlwr      (O_DLWR),
        .dladdr    (O_DLADDR),
        .dldata    (O_DLDATA),
        .idle      (pacer_idle)
    );

    // State register. dl_q follows the input even in reset so a session that
    // was live when reset hit is abandoned rather than re-entered.
    always_ff @(posedge I_CLK_48M) begin
        if (!I_RESETn) begin
            state <= ST_IDLE;
            dl_q  <= I_DL_ACTIVE;
        end else begin
            state <= state_nxt;
            dl_q  <= I_DL_ACTIVE;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (dl_rise)    state_nxt = ST_LOAD;
            ST_LOAD:  if (dl_fall)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (pacer_idle) state_nxt = ST_DONE;
            ST_DONE:  if (dl_rise)    state_nxt = ST_LOAD;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        O_DONE = (state == ST_DONE);
        O_MUTE = !((state == ST_DONE) && (bytes_q == WIN_SIZE) && !overrun_q);
    end

    always_ff @(posedge I_CLK_48M) begin
        if (!I_RESETn) begin
            bytes_q   <= '0;
            overrun_q <= 1'b0;
        end else if (enter_load) begin
            bytes_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (O_DLWR && (bytes_q != WIN_SIZE)) begin
                bytes_q <= bytes_q + 1'b1;
            end
            if (strobe_hit && O_IOCTL_WAIT) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign O_BYTES   = bytes_q;
    assign O_OVERRUN = overrun_q;

`ifdef WAVLD_CHKSUM_EN
    logic [15:0] chksum_q;

    always_ff @(posedge I_CLK_48M) begin
        if (!I_RESETn) begin
            chksum_q <= 16'h0000;
        end else if (enter_load) begin
            chksum_q <= 16'h0000;
        end else if (O_DLWR) begin
            chksum_q <= chksum_q + {8'h00, O_DLDATA};
        end
    end

    assign O_CHKSUM = chksum_q;
`else
    assign O_CHKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_mario_wav_loader.sv
// tb/tb_mario_wav_loader.sv - directed self-checking bench for mario_wav_loader
module tb_mario_wav_loader;

    localparam int WR_GAP = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dl_active;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [16:0] dladdr;
    logic [7:0]  dldata;
    logic        dlwr;
    logic        mute;
    logic        done;
    logic        overrun;
    logic [16:0] bytes_cnt;
    logic [15:0] chksum;

    int vectors     = 0;
    int miscompares = 0;
    int timeouts    = 0;
    int cyc         = 0;
    int pulse_cnt   = 0;
    int last_wr     = 0;
    int min_gap     = 1000;

    mario_wav_loader #(
        .BASE_ADDR (25'h0010000),
        .WIN_SIZE  (17'h04000),
        .WR_GAP    (WR_GAP)
    ) dut (
        .I_CLK_48M    (clk),
        .I_RESETn     (resetn),
        .I_DL_ACTIVE  (dl_active),
        .I_IOCTL_ADDR (ioctl_addr),
        .I_IOCTL_DATA (ioctl_data),
        .I_IOCTL_WR   (ioctl_wr),
        .O_IOCTL_WAIT (ioctl_wait),
        .O_DLADDR     (dladdr),
        .O_DLDATA     (dldata),
        .O_DLWR       (dlwr),
        .O_MUTE       (mute),
        .O_DONE       (done),
        .O_OVERRUN    (overrun),
        .O_BYTES      (bytes_cnt),
        .O_CHKSUM     (chksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counter and minimum pulse spacing, sampled mid-cycle
    always @(negedge clk) begin
        if (dlwr) begin
            if (pulse_cnt > 0 && (cyc - last_wr) < min_gap) min_gap = cyc - last_wr;
            last_wr = cyc;
            pulse_cnt = pulse_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ioctl_wait && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) timeouts++;
    endtask

    // Honors WAIT, then strobes one byte; returns one clock after the strobe
    task automatic host_write(input logic [24:0] a, input logic [7:0] d);
        wait_ready();
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeouts++;
    endtask

    task automatic start_session();
        dl_active = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int p0;
        int bad;
        logic [15:0] exp_sum;

        resetn     = 1'b0;
        dl_active  = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_mute", mute, 1);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bytes", bytes_cnt, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_dlwr", dlwr, 0);
        chk("rst_chksum", chksum, 0);
        resetn = 1'b1;
        tick();

        // Session A: out-of-window strobes, three bytes, last one on the falling edge
        start_session();
        p0 = pulse_cnt;
        host_write(25'h000FFFF, 8'h11);
        chk("below_win_dlwr", dlwr, 0);
        chk("below_win_wait", ioctl_wait, 0);
        host_write(25'h0014000, 8'h22);
        chk("above_win_dlwr", dlwr, 0);
        chk("above_win_wait", ioctl_wait, 0);
        tick();
        chk("outside_pulses", pulse_cnt - p0, 0);
        chk("outside_bytes", bytes_cnt, 0);

        host_write(25'h0010000, 8'hFF);
        chk("first_dlwr_latency", dlwr, 1);
        chk("first_dladdr", dladdr, 17'h00000);
        chk("first_dldata", dldata, 8'hFF);
        chk("wait_after_accept", ioctl_wait, 1);
        host_write(25'h0010001, 8'h02);
        wait_ready();
        ioctl_addr = 25'h0010002;
        ioctl_data = 8'h10;
        ioctl_wr   = 1'b1;
        dl_active  = 1'b0;
        tick();
        ioctl_wr   = 1'b0;
        wait_done();
        chk("a_done", done, 1);
        chk("a_bytes", bytes_cnt, 3);
        chk("a_last_dladdr", dladdr, 17'h00002);
        chk("a_last_dldata", dldata, 8'h10);
        chk("a_mute_partial", mute, 1);
        chk("a_overrun", overrun, 0);
`ifdef WAVLD_CHKSUM_EN
        exp_sum = 16'h0111;
`else
        exp_sum = 16'h0000;
`endif
        chk("a_chksum", chksum, exp_sum);

        // Session B: strobe one clock after an accepted byte
        start_session();
        chk("b_bytes_cleared", bytes_cnt, 0);
        chk("b_done_cleared", done, 0);
        chk("b_chksum_cleared", chksum, 0);
        host_write(25'h0010005, 8'hAA);
        chk("b_wait_high", ioctl_wait, 1);
        ioctl_addr = 25'h0010006;
        ioctl_data = 8'hBB;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        chk("b_overrun", overrun, 1);
        repeat (4) tick();
        chk("b_bytes", bytes_cnt, 1);
        chk("b_dladdr", dladdr, 17'h00005);
        chk("b_dldata", dldata, 8'hAA);
        dl_active = 1'b0;
        tick();
        wait_done();
        chk("b_done", done, 1);
        chk("b_mute", mute, 1);
        chk("b_overrun_sticky", overrun, 1);

        // Session C: full window plus one duplicate
        start_session();
        chk("c_overrun_cleared", overrun, 0);
        p0 = pulse_cnt;
        bad = 0;
        for (int i = 0; i < 16384; i++) begin
            host_write(25'h0010000 + 25'(i), 8'(i) ^ 8'h5A);
            if (dlwr !== 1'b1 || dladdr !== 17'(i) || dldata !== (8'(i) ^ 8'h5A)) bad++;
        end
        chk("c_write_stream_errors", bad, 0);
        repeat (3) tick();
        chk("c_pulses", pulse_cnt - p0, 16384);
        chk("c_bytes_full", bytes_cnt, 17'h04000);
        chk("c_mute_before_end", mute, 1);
        chk("c_done_before_end", done, 0);
        host_write(25'h0010000, 8'h77);
        repeat (3) tick();
        chk("c_dup_pulses", pulse_cnt - p0, 16385);
        chk("c_bytes_saturated", bytes_cnt, 17'h04000);
        chk("c_dup_dladdr", dladdr, 17'h00000);
        chk("c_gap_min_ok", (min_gap >= WR_GAP) ? 1 : 0, 1);
        dl_active = 1'b0;
        tick();
        wait_done();
        chk("c_done", done, 1);
        chk("c_unmuted", mute, 0);
        chk("c_overrun", overrun, 0);

        // Session D: incomplete window
        start_session();
        chk("d_mute_on_load", mute, 1);
        for (int i = 0; i < 16'h0800; i++) host_write(25'h0012000 + 25'(i), 8'(i));
        dl_active = 1'b0;
        tick();
        wait_done();
        chk("d_done", done, 1);
        chk("d_bytes", bytes_cnt, 17'h00800);
        chk("d_mute", mute, 1);
        chk("d_last_dladdr", dladdr, 17'h027FF);

        // Session E: reset mid-load after 100 bytes
        start_session();
        for (int i = 0; i < 100; i++) host_write(25'h0010100 + 25'(i), 8'(i));
        repeat (3) tick();
        chk("e_bytes_pre_reset", bytes_cnt, 100);
        resetn = 1'b0;
        tick();
        chk("e_rst_bytes", bytes_cnt, 0);
        chk("e_rst_done", done, 0);
        chk("e_rst_mute", mute, 1);
        chk("e_rst_wait", ioctl_wait, 0);
        resetn = 1'b1;
        tick();
        tick();
        p0 = pulse_cnt;
        host_write(25'h0010000, 8'h33);
        tick();
        chk("e_idle_ignores_pulses", pulse_cnt - p0, 0);
        chk("e_idle_bytes", bytes_cnt, 0);
        dl_active = 1'b0;
        repeat (4) tick();
        chk("e_still_idle_done", done, 0);

        chk("timeouts", timeouts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
